// File: rtl/output_scaler_ctrl.sv
// Sequencer and parameter bank for one output_scaler: channel-major accumulator stream in,
// packed scaled lanes out. Define OUTPUT_SCALER_CTRL_PERCHAN_EN for a per-channel bank.
module output_scaler_ctrl #(
  parameter int unsigned numChannels    = 32,
  parameter int unsigned inputWidth     = 20,
  parameter int unsigned maxOutputWidth = 8,
  parameter int unsigned fixedPointBits = 16,
  parameter int unsigned shiftBits      = 16,
  parameter int unsigned packWidth      = 32,
  localparam int unsigned CW            = $clog2(numChannels),
  localparam int unsigned L             = packWidth / maxOutputWidth,
  localparam int unsigned LW            = (L > 1) ? $clog2(L) : 1
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      cfg_wr_en,
  input  logic [CW-1:0]             cfg_wr_addr,
  input  logic [fixedPointBits-1:0] cfg_wr_scale,
  input  logic [shiftBits-1:0]      cfg_wr_shift,
  input  logic [31:0]               cfg_wr_bias,
  input  logic [CW:0]               cfg_num_channels,
  input  logic [15:0]               cfg_num_pixels,
  input  logic                      start_i,
  output logic                      done_o,
  output logic                      busy_o,
  output logic                      cfg_err_o,
  input  logic                      acc_valid_i,
  output logic                      acc_ready_o,
  input  logic [inputWidth-1:0]     acc_data_i,
  output logic [inputWidth-1:0]     sc_wx_o,
  output logic [fixedPointBits-1:0] sc_scale_o,
  output logic [shiftBits-1:0]      sc_shift_o,
  output logic [31:0]               sc_bias_o,
  input  logic [maxOutputWidth-1:0] sc_y_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [packWidth-1:0]      out_data_o,
  output logic                      out_last_o
);

`ifdef OUTPUT_SCALER_CTRL_PERCHAN_EN
  localparam int unsigned BankDepth = numChannels;
`else
  localparam int unsigned BankDepth = 1;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  state_e state_q, state_d;

  logic [fixedPointBits-1:0] scale_q [BankDepth];
  logic [shiftBits-1:0]      shift_q [BankDepth];
  logic [31:0]               bias_q  [BankDepth];

  logic [CW:0]             num_ch_q;
  logic [15:0]             num_pix_q, pix_q;
  logic [CW-1:0]           ch_q, r1_ch_q;
  logic [LW-1:0]           lane_q;
  logic                    r1_valid_q, r1_last_q, err_q;
  logic [inputWidth-1:0]   r1_wx_q;
  logic [packWidth-1:0]    pack_q, pack_merge, out_data_q;
  logic                    out_valid_q, out_last_q;

  logic cnt_ok, run_start, err_set, bank_we;
  logic ch_last, pix_last, word_done, r1_adv, acc_fire;

  assign cnt_ok    = (cfg_num_channels != '0) && (cfg_num_channels <= (CW+1)'(numChannels)) &&
                     (cfg_num_pixels != '0);
  assign ch_last   = ({1'b0, ch_q} == num_ch_q - 1'b1);
  assign pix_last  = (pix_q == num_pix_q - 16'd1);
  // Each pixel starts a fresh word, so the last channel always closes one.
  assign word_done = (lane_q == LW'(L - 1)) || ({1'b0, r1_ch_q} == num_ch_q - 1'b1);
  assign r1_adv    = r1_valid_q && !(word_done && out_valid_q && !out_ready_i);
  assign acc_ready_o = (state_q == StRun) && !(r1_valid_q && !r1_adv);
  assign acc_fire  = acc_valid_i && acc_ready_o;

  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    err_set   = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (cnt_ok) begin
            state_d   = StRun;
            run_start = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      StRun:   if (acc_fire && ch_last && pix_last) state_d = StDrain;
      StDrain: begin
        if (out_valid_q && out_ready_i && out_last_q) begin
          state_d = StIdle;
          done_o  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (cfg_wr_en && (state_q != StIdle)) err_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | err_set;
    end
  end

`ifdef OUTPUT_SCALER_CTRL_PERCHAN_EN
  assign bank_we    = cfg_wr_en && (state_q == StIdle);
  assign sc_scale_o = scale_q[r1_ch_q];
  assign sc_shift_o = shift_q[r1_ch_q];
  assign sc_bias_o  = bias_q[r1_ch_q];
`else
  assign bank_we    = cfg_wr_en && (state_q == StIdle) && (cfg_wr_addr == '0);
  assign sc_scale_o = scale_q[0];
  assign sc_shift_o = shift_q[0];
  assign sc_bias_o  = bias_q[0];
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < BankDepth; i++) begin
        scale_q[i] <= '0;
        shift_q[i] <= '0;
        bias_q[i]  <= '0;
      end
    end else if (bank_we) begin
`ifdef OUTPUT_SCALER_CTRL_PERCHAN_EN
      scale_q[cfg_wr_addr] <= cfg_wr_scale;
      shift_q[cfg_wr_addr] <= cfg_wr_shift;
      bias_q[cfg_wr_addr]  <= cfg_wr_bias;
`else
      scale_q[0] <= cfg_wr_scale;
      shift_q[0] <= cfg_wr_shift;
      bias_q[0]  <= cfg_wr_bias;
`endif
    end
  end

  always_comb begin
    pack_merge = pack_q;
    for (int i = 0; i < L; i++) begin
      if (lane_q == LW'(i)) pack_merge[i*maxOutputWidth +: maxOutputWidth] = sc_y_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      num_ch_q    <= '0;
      num_pix_q   <= '0;
      ch_q        <= '0;
      pix_q       <= '0;
      r1_valid_q  <= 1'b0;
      r1_wx_q     <= '0;
      r1_ch_q     <= '0;
      r1_last_q   <= 1'b0;
      lane_q      <= '0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (run_start) begin
        num_ch_q  <= cfg_num_channels;
        num_pix_q <= cfg_num_pixels;
        ch_q      <= '0;
        pix_q     <= '0;
      end else if (acc_fire) begin
        if (ch_last) begin
          ch_q  <= '0;
          pix_q <= pix_q + 16'd1;
        end else begin
          ch_q <= ch_q + 1'b1;
        end
      end

      if (acc_fire) begin
        r1_valid_q <= 1'b1;
        r1_wx_q    <= acc_data_i;
        r1_ch_q    <= ch_q;
        r1_last_q  <= ch_last && pix_last;
      end else if (r1_adv) begin
        r1_valid_q <= 1'b0;
      end

      if (run_start || (r1_adv && word_done)) begin
        lane_q <= '0;
        pack_q <= '0;
      end else if (r1_adv) begin
        lane_q <= lane_q + 1'b1;
        pack_q <= pack_merge;
      end

      // A completing word may replace a word draining in this same cycle.
      if (r1_adv && word_done) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pack_merge;
        out_last_q  <= r1_last_q;
      end else if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign cfg_err_o   = err_q;
  assign sc_wx_o     = r1_wx_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

endmodule
